// File: rtl/delay_pkg.sv
// Shared definitions for the variable delay line: delay clamping, dly width
// derivation and the drop counter width.
package delay_pkg;

  localparam int DROP_CNT_W = 16;

  // Width needed to carry any requested delay 0..max_d.
  function automatic int dly_width(input int max_d);
    return $clog2(max_d + 1);
  endfunction

  // Effective delay: requests outside 1..max_d are pinned to the nearest bound.
  function automatic int clamp_dly(input int d, input int max_d);
    if (d < 1) return 1;
    if (d > max_d) return max_d;
    return d;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port storage for the delay line: one write port, one registered
// read port with read-before-write behaviour, no reset on the contents.
module delay_ram #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16,
  parameter int A_W   = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [A_W-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [A_W-1:0]   raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Reading the slot being overwritten returns the old entry, which is what
  // gives the full MAX_D cycle delay when the read and write addresses meet.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/delay_var.sv
// Runtime-programmable delay line for multi-lane data with a valid qualifier.
// Optional build macro DELAY_STATUS_EN adds the drop_cnt status output.
module delay_var
  import delay_pkg::*;
#(
  parameter int BITWIDTH  = 64,
  parameter int CHANNELS  = 1,
  parameter int MAX_D     = 16,
  parameter int DEFAULT_D = 1,
  parameter int D_W       = dly_width(MAX_D)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS*BITWIDTH-1:0] din,
  input  logic                         din_valid,
  input  logic [D_W-1:0]               dly,
  output logic [CHANNELS*BITWIDTH-1:0] dout,
  output logic                         dout_valid,
  output logic                         dly_clamped
`ifdef DELAY_STATUS_EN
  ,
  output logic [DROP_CNT_W-1:0]        drop_cnt
`endif
);

  localparam int W   = CHANNELS * BITWIDTH;
  localparam int A_W = $clog2(MAX_D);

  logic [D_W-1:0]   l_next;
  logic [D_W-1:0]   dly_q;
  logic [D_W-1:0]   dly_prev;
  logic             chg;
  logic [A_W-1:0]   wr_ptr;
  logic [D_W:0]     rd_raw;
  logic [A_W-1:0]   rd_idx;
  logic [A_W-1:0]   tap;
  logic [MAX_D-1:0] vld_hist;
  logic [W-1:0]     rd_data_p1;
  logic             rst_p1;

  // ---- stage 0: delay request, pointer arithmetic ----
  assign l_next = D_W'(clamp_dly(int'(dly), MAX_D));
  assign chg    = (dly_q != dly_prev);
  assign tap    = A_W'(dly_q - 1'b1);

  always_comb begin
    rd_raw = (D_W+1)'(wr_ptr) + (D_W+1)'(MAX_D) - (D_W+1)'(dly_q);
    if (rd_raw >= (D_W+1)'(MAX_D))
      rd_idx = A_W'(rd_raw - (D_W+1)'(MAX_D));
    else
      rd_idx = A_W'(rd_raw);
  end

  delay_ram #(
    .WIDTH (W),
    .DEPTH (MAX_D),
    .A_W   (A_W)
  ) u_ram (
    .clk   (clk),
    .we    (1'b1),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_idx),
    .rdata (rd_data_p1)
  );

  // ---- stage 1: registered control and valid history ----
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      dly_q       <= D_W'(DEFAULT_D);
      dly_prev    <= D_W'(DEFAULT_D);
      dly_clamped <= 1'b0;
      vld_hist    <= '0;
      dout_valid  <= 1'b0;
      rst_p1      <= 1'b1;
    end else begin
      wr_ptr      <= (wr_ptr == A_W'(MAX_D - 1)) ? '0 : wr_ptr + 1'b1;
      dly_q       <= l_next;
      dly_prev    <= dly_q;
      dly_clamped <= (l_next != dly);
      rst_p1      <= 1'b0;
      // A delay change flushes every sample captured under the old delay;
      // the sample arriving in the change cycle itself is kept.
      if (chg) begin
        vld_hist   <= {{(MAX_D-1){1'b0}}, din_valid};
        dout_valid <= 1'b0;
      end else begin
        vld_hist   <= {vld_hist[MAX_D-2:0], din_valid};
        dout_valid <= vld_hist[tap];
      end
    end
  end

  // Data storage carries no reset, so the first output after reset is forced
  // to zero here rather than in the RAM.
  assign dout = rst_p1 ? '0 : rd_data_p1;

`ifdef DELAY_STATUS_EN
  logic [D_W-1:0] drop_n;

  function automatic logic [DROP_CNT_W-1:0] sat_add(
    input logic [DROP_CNT_W-1:0] a,
    input logic [D_W-1:0]        b
  );
    logic [DROP_CNT_W:0] s;
    s = {1'b0, a} + (DROP_CNT_W+1)'(b);
    return s[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : s[DROP_CNT_W-1:0];
  endfunction

  // Valid samples still in flight under the old delay are the ones discarded.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < MAX_D; i++)
      if (i < int'(dly_prev)) drop_n = drop_n + D_W'(vld_hist[i]);
  end

  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (chg)
      drop_cnt <= sat_add(drop_cnt, drop_n);
  end
`endif

endmodule
